redirect_ctrl: RTL
==================

Name: redirect_ctrl

Overview:
- Sequences every front-end redirect in the core.
- Takes the EX-stage branch outcome (mispredict, actual taken, actual target, BTB-update request), JAL/JALR, fence jumps and CLINT interrupts, then:
  - arbitrates one redirect at a time by fixed priority;
  - hands it to fetch with a valid/ready handshake;
  - stalls EX until fetch accepts;
  - pulses pipeline flushes;
  - issues the registered BTB write.
- Sits between EX/branch_decision, the CLINT, the fence logic and the IF/BTB.

Parameters:
- ADDR_W, 32 (`BUS_WIDTH): PC/target width.
- CNT_W, 32: mispredict counter width.
- INSN_BYTES, 4: sequential PC increment.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a valid instruction this cycle
- pc_ex  in  ADDR_W  PC of EX instruction
- branch_req  in  1  EX instruction is a conditional branch
- jal_ex  in  1  EX instruction is JAL
- jalr_ex  in  1  EX instruction is JALR
- branch_res  in  1  branch mispredicted (direction or target)
- branch_cal  in  1  branch actually taken
- update_btb  in  1  predictor must be corrected
- pc_branch_addr_ex  in  ADDR_W  computed branch/jump target
- clint_int_assert  in  1  interrupt redirect request
- clint_int_addr  in  ADDR_W  trap vector
- fence_jump  in  1  fence refetch request
- fence_pc  in  ADDR_W  refetch PC
- redirect_ready  in  1  fetch accepts redirect
- redirect_valid  out  1  redirect pending
- redirect_pc  out  ADDR_W  new fetch PC
- stall_ex  out  1  freeze EX and earlier stages
- flush_if_id  out  1  flush IF/ID register
- flush_id_ex  out  1  flush ID/EX register
- flush_ex_mem  out  1  flush EX/MEM register (interrupt only)
- btb_we  out  1  BTB write strobe
- btb_wpc  out  ADDR_W  BTB write index PC
- btb_wtarget  out  ADDR_W  BTB write target
- btb_wtaken  out  1  BTB write taken bit
- mispredict_cnt  out  CNT_W  saturating mispredict/jump-correction count

Behaviour:
- Reset (async, rst_n=0): state IDLE. Every output 0, including redirect_pc, btb_* and mispredict_cnt. Reset mid-WAIT_ACK discards the pending redirect.
- States:
  - IDLE: no redirect pending.
  - WAIT_ACK: redirect_valid=1, stall_ex=1.
  - FLUSH: one cycle; flush_if_id=flush_id_ex=1; flush_ex_mem=1 if cause==INT.
- Cause priority, evaluated in IDLE: INT > FENCE > MISPRED > JUMP.
  - INT = clint_int_assert; does not require ex_valid.
  - FENCE = ex_valid & fence_jump.
  - MISPRED = ex_valid & branch_req & branch_res.
  - JUMP = ex_valid & (jal_ex|jalr_ex) & update_btb.
- Targets:
  - INT: clint_int_addr.
  - FENCE: fence_pc.
  - MISPRED: branch_cal ? pc_branch_addr_ex : pc_ex+INSN_BYTES. Addition is mod 2^ADDR_W; wrap allowed.
  - JUMP: pc_branch_addr_ex.
- Transitions:
  - IDLE to WAIT_ACK: on any cause. Target and cause are registered; redirect_valid rises the next cycle (latency 1).
  - WAIT_ACK to FLUSH: on redirect_valid & redirect_ready.
  - FLUSH to IDLE: always.
- Handshake: redirect_pc and redirect_valid are stable while redirect_ready=0. Fetch may hold ready low indefinitely.
- Preemption:
  - clint_int_assert in WAIT_ACK with a pending non-INT cause and ready=0: pc and cause are overwritten with the INT target, same cycle.
  - If ready=1 in that same cycle: the current handshake completes, and the INT is captured and presented after FLUSH.
- INT arriving in FLUSH or WAIT_ACK(INT): held by CLINT (level); taken on return to IDLE.
- Ignored inputs: EX-derived causes in WAIT_ACK/FLUSH, since EX is stalled or flushed.
- BTB write: in IDLE, ex_valid & update_btb & (branch_req|jal_ex|jalr_ex) and no INT/FENCE this cycle gives btb_we=1 for exactly one cycle, one cycle later, with:
  - btb_wpc = pc_ex;
  - btb_wtarget = pc_branch_addr_ex;
  - btb_wtaken = branch_cal|jal_ex|jalr_ex.
  - A BTB write for a not-taken branch (type/direction correction) still occurs.
- mispredict_cnt: +1 on each IDLE capture of MISPRED or JUMP; saturates at all-ones.

Decomposition:
- Shared package/include: cause encoding (INT=2'd3, FENCE=2'd2, MISPRED=2'd1, JUMP=2'd0) and state encoding (IDLE/WAIT_ACK/FLUSH).
- ADDR_W comes from `BUS_WIDTH.
- One natural sub-module: redirect_prio_sel, a combinational priority/target mux.
- FSM, BTB write register and counter stay in the top.

Test Plan:
- Mispredict, taken: pc_ex=0x100, branch_req=1, branch_res=1, branch_cal=1, target=0x180, update_btb=1, ready=1. Next cycle redirect_valid=1, redirect_pc=0x180, btb_we=1 (wpc 0x100, target 0x180, taken=1). Then FLUSH one cycle; mispredict_cnt=1.
- Mispredict, not taken: pc_ex=0x200, branch_cal=0. Required: redirect_pc=0x204, btb_wtaken=0. Also pc_ex=0xFFFFFFFC wraps to redirect_pc=0x0.
- Held handshake: ready=0 for 5 cycles. Required: redirect_valid and pc stable, stall_ex=1 throughout, EX mispredict stimuli ignored, and FLUSH only after ready=1.
- Preemption: pending JUMP to 0x300, ready=0, clint_int_assert with vector 0x8. Required: redirect_pc becomes 0x8, and flush_ex_mem=1 in FLUSH.
- Same-cycle conflict in IDLE: fence_jump with fence_pc=0x40 plus branch_res. Required: redirect_pc=0x40, no btb_we, counter unchanged.
- Reset mid-WAIT_ACK with rst_n pulse: all outputs 0 immediately (async). After release, IDLE with no redirect.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// redirect_ctrl_pkg: shared redirect cause/state encodings and bus width
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
package redirect_ctrl_pkg;
  localparam int BUS_W = `BUS_WIDTH;
  typedef enum logic [1:0] {
    C_JUMP    = 2'd0,
    C_MISPRED = 2'd1,
    C_FENCE   = 2'd2,
    C_INT     = 2'd3
  } cause_t;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;
endpackage

// File: rtl/redirect_prio_sel.sv
// redirect_prio_sel: fixed-priority redirect cause and target selection
module redirect_prio_sel
  import redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W     = BUS_W,
  parameter int INSN_BYTES = 4
) (
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] pc_ex,
  input  logic              branch_req,
  input  logic              jal_ex,
  input  logic              jalr_ex,
  input  logic              branch_res,
  input  logic              branch_cal,
  input  logic              update_btb,
  input  logic [ADDR_W-1:0] pc_branch_addr_ex,
  input  logic              clint_int_assert,
  input  logic [ADDR_W-1:0] clint_int_addr,
  input  logic              fence_jump,
  input  logic [ADDR_W-1:0] fence_pc,
  output logic              hit,
  output logic [1:0]        cause,
  output logic [ADDR_W-1:0] target
);
  logic int_c, fence_c, mis_c, jmp_c;
  logic [ADDR_W-1:0] seq_pc;
  always_comb begin
    int_c   = clint_int_assert;
    fence_c = ex_valid & fence_jump;
    mis_c   = ex_valid & branch_req & branch_res;
    jmp_c   = ex_valid & (jal_ex | jalr_ex) & update_btb;
    seq_pc  = pc_ex + ADDR_W'(INSN_BYTES);
    hit     = int_c | fence_c | mis_c | jmp_c;
    cause   = int_c ? C_INT : fence_c ? C_FENCE : mis_c ? C_MISPRED : C_JUMP;
    target  = int_c ? clint_int_addr : fence_c ? fence_pc :
              (mis_c & ~branch_cal) ? seq_pc : pc_branch_addr_ex;
  end
endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: front-end redirect sequencer with fetch handshake, flushes, BTB write and mispredict count
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W     = BUS_W,
  parameter int CNT_W      = 32,
  parameter int INSN_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] pc_ex,
  input  logic              branch_req,
  input  logic              jal_ex,
  input  logic              jalr_ex,
  input  logic              branch_res,
  input  logic              branch_cal,
  input  logic              update_btb,
  input  logic [ADDR_W-1:0] pc_branch_addr_ex,
  input  logic              clint_int_assert,
  input  logic [ADDR_W-1:0] clint_int_addr,
  input  logic              fence_jump,
  input  logic [ADDR_W-1:0] fence_pc,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              stall_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              btb_we,
  output logic [ADDR_W-1:0] btb_wpc,
  output logic [ADDR_W-1:0] btb_wtarget,
  output logic              btb_wtaken,
  output logic [CNT_W-1:0]  mispredict_cnt
);
  state_t state;
  logic [1:0] cause, sel_cause;
  logic sel_hit, btb_hit, corr;
  logic [ADDR_W-1:0] sel_target;
  redirect_prio_sel #(.ADDR_W(ADDR_W), .INSN_BYTES(INSN_BYTES)) u_sel (
    .ex_valid(ex_valid), .pc_ex(pc_ex), .branch_req(branch_req), .jal_ex(jal_ex),
    .jalr_ex(jalr_ex), .branch_res(branch_res), .branch_cal(branch_cal),
    .update_btb(update_btb), .pc_branch_addr_ex(pc_branch_addr_ex),
    .clint_int_assert(clint_int_assert), .clint_int_addr(clint_int_addr),
    .fence_jump(fence_jump), .fence_pc(fence_pc),
    .hit(sel_hit), .cause(sel_cause), .target(sel_target)
  );
  always_comb begin
    btb_hit = ex_valid & update_btb & (branch_req | jal_ex | jalr_ex) & ~clint_int_assert & ~fence_jump;
    corr    = sel_hit & (sel_cause == C_MISPRED || sel_cause == C_JUMP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cause          <= C_JUMP;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_ex       <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      flush_ex_mem   <= 1'b0;
      btb_we         <= 1'b0;
      btb_wpc        <= '0;
      btb_wtarget    <= '0;
      btb_wtaken     <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      btb_we       <= 1'b0;
      flush_if_id  <= 1'b0;
      flush_id_ex  <= 1'b0;
      flush_ex_mem <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_hit) begin
            state          <= S_WAIT_ACK;
            cause          <= sel_cause;
            redirect_pc    <= sel_target;
            redirect_valid <= 1'b1;
            stall_ex       <= 1'b1;
          end
          if (btb_hit) begin
            btb_we      <= 1'b1;
            btb_wpc     <= pc_ex;
            btb_wtarget <= pc_branch_addr_ex;
            btb_wtaken  <= branch_cal | jal_ex | jalr_ex;
          end
          if (corr && !(&mispredict_cnt))
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
        S_WAIT_ACK: begin
          if (redirect_ready) begin
            state          <= S_FLUSH;
            redirect_valid <= 1'b0;
            stall_ex       <= 1'b0;
            flush_if_id    <= 1'b1;
            flush_id_ex    <= 1'b1;
            flush_ex_mem   <= (cause == C_INT);
          end else if (clint_int_assert && cause != C_INT) begin
            // an interrupt displaces a not-yet-accepted redirect in place
            cause       <= C_INT;
            redirect_pc <= clint_int_addr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
